// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg: shared types, widths and helpers for the round-robin stream mux.
//   mode_e        : channel selection mode (fixed select / round-robin)
//   CNT_W         : width of the optional output-handshake counter
//   onehot_to_idx : one-hot grant vector (up to MAX_CH bits) to binary index
package rr_stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned MAX_CH    = 16;
  localparam int unsigned IDX_MAX_W = 4;

  // OR of the indices of all set bits; exact for a one-hot or all-zero input.
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority arbiter.
//   req       : per-channel request
//   ptr       : last granted channel; search starts at ptr+1 and wraps
//   enable    : when low no grant is issued
//   grant     : one-hot grant (all zero when nothing granted)
//   grant_idx : binary index of the granted channel
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  input  logic                      enable,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  logic [IDX_W:0]      cand_c;
  logic                found_c;
  logic [MAX_CH-1:0]   grant_ext_c;

  // Walk ptr+1 .. ptr+NUM_CH (mod NUM_CH); first requester wins.
  always_comb begin
    grant   = '0;
    found_c = 1'b0;
    cand_c  = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      cand_c = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand_c >= (IDX_W+1)'(NUM_CH)) cand_c = cand_c - (IDX_W+1)'(NUM_CH);
      if (enable && !found_c && req[cand_c[IDX_W-1:0]]) begin
        grant[cand_c[IDX_W-1:0]] = 1'b1;
        found_c                  = 1'b1;
      end
    end
  end

  // Widen the grant to the helper's fixed width before encoding.
  always_comb begin
    grant_ext_c               = '0;
    grant_ext_c[NUM_CH-1:0]   = grant;
    grant_idx                 = IDX_W'(onehot_to_idx(grant_ext_c));
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream mux with one registered output stage.
// Selection is fixed (sel_i) or round-robin, chosen every cycle by mode_i.
//   clk, reset : clock and synchronous active-high reset
//   mode_i     : 0 = fixed select, 1 = round-robin
//   sel_i      : channel index used in fixed mode
//   valid_i    : per-channel valid; data_i holds channel k at [k*WIDTH +: WIDTH]
//   ready_o    : per-channel ready (combinational, at most one bit set)
//   valid_o    : output register holds a word; data_o/ch_o give word and source
//   ready_i    : downstream ready
//   xfer_cnt_o : saturating output-handshake count, present only when
//                RR_STREAM_MUX_CNT_EN is defined
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode_i,
  input  logic [$clog2(NUM_CH)-1:0] sel_i,
  input  logic [NUM_CH-1:0]         valid_i,
  input  logic [NUM_CH*WIDTH-1:0]   data_i,
  output logic [NUM_CH-1:0]         ready_o,
  output logic                      valid_o,
  output logic [WIDTH-1:0]          data_o,
  output logic [$clog2(NUM_CH)-1:0] ch_o,
  input  logic                      ready_i
`ifdef RR_STREAM_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0]          xfer_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0]  ptr_q;
  logic              load_en_c;
  logic [NUM_CH-1:0] sel_mask_c;
  logic [NUM_CH-1:0] req_c;
  logic [NUM_CH-1:0] grant_c;
  logic [IDX_W-1:0]  grant_idx_c;
  logic              xfer_c;
  logic [WIDTH-1:0]  data_sel_c;

  assign load_en_c = !valid_o || ready_i;

  // Decode sel_i; an out-of-range select matches no channel.
  always_comb begin
    sel_mask_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sel_mask_c[k] = (sel_i == IDX_W'(k));
    end
  end

  // Fixed mode reuses the arbiter with a single-candidate request vector.
  assign req_c = (mode_e'(mode_i) == MODE_RR) ? valid_i : (valid_i & sel_mask_c);

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req       (req_c),
    .ptr       (ptr_q),
    .enable    (load_en_c && !reset),
    .grant     (grant_c),
    .grant_idx (grant_idx_c)
  );

  assign ready_o = grant_c;
  assign xfer_c  = |grant_c;

  // AND-OR data select driven by the one-hot grant.
  always_comb begin
    data_sel_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_c[k]) data_sel_c = data_sel_c | data_i[k*WIDTH +: WIDTH];
    end
  end

  // Output register and priority pointer; drain without reload only clears valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      ch_o    <= '0;
      ptr_q   <= IDX_W'(NUM_CH - 1);
    end else if (xfer_c) begin
      valid_o <= 1'b1;
      data_o  <= data_sel_c;
      ch_o    <= grant_idx_c;
      ptr_q   <= grant_idx_c;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifdef RR_STREAM_MUX_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of output handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (valid_o && ready_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign xfer_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_rr_stream_mux;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IDX_W  = 2;

  logic                    clk;
  logic                    reset;
  logic                    mode_i;
  logic [IDX_W-1:0]        sel_i;
  logic [NUM_CH-1:0]       valid_i;
  logic [NUM_CH*WIDTH-1:0] data_i;
  logic                    ready_i;
  logic [NUM_CH-1:0]       ready_o;
  logic                    valid_o;
  logic [WIDTH-1:0]        data_o;
  logic [IDX_W-1:0]        ch_o;
`ifdef RR_STREAM_MUX_CNT_EN
  logic [15:0]             xfer_cnt_o;
`endif

  int total;
  int bad;

  rr_stream_mux #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_i     (mode_i),
    .sel_i      (sel_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .ch_o       (ch_o),
    .ready_i    (ready_i)
`ifdef RR_STREAM_MUX_CNT_EN
    ,
    .xfer_cnt_o (xfer_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: which channel the rules say gets the grant, or -1.
  function automatic int model_grant(input logic [NUM_CH-1:0] v, input logic m,
                                     input int sel, input int ptr);
    int c;
    if (!m) return (sel < NUM_CH && v[sel]) ? sel : -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (ptr + k) % NUM_CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Model state: contents of the output register, last grant, handshake count.
  bit                m_known = 1'b0;
  bit                m_valid;
  int                m_data;
  int                m_ch;
  int                m_ptr;
  int                m_cnt;
  int                g;
  bit                load_en;
  logic [NUM_CH-1:0] exp_ready;

  // Compare outputs on every falling edge, then advance the model by one cycle.
  always @(negedge clk) begin
    g         = -1;
    exp_ready = '0;
    if (m_known) begin
      if (!reset) begin
        load_en = !m_valid || ready_i;
        g = model_grant(valid_i, mode_i, int'(sel_i), m_ptr);
        if (!load_en) g = -1;
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("m_ready_o", 32'(ready_o), 32'(exp_ready));
      check("m_valid_o", 32'(valid_o), 32'(m_valid));
      check("m_data_o",  32'(data_o),  32'(m_data));
      check("m_ch_o",    32'(ch_o),    32'(m_ch));
`ifdef RR_STREAM_MUX_CNT_EN
      check("m_xfer_cnt", 32'(xfer_cnt_o), 32'(m_cnt));
`endif
    end
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 0;
      m_ch    = 0;
      m_ptr   = NUM_CH - 1;
      m_cnt   = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (m_valid && ready_i && m_cnt < 65535) m_cnt++;
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = int'(data_i[g*WIDTH +: WIDTH]);
        m_ch    = g;
        m_ptr   = g;
      end else if (ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    // Reset with every channel requesting and downstream ready.
    reset   = 1'b1;
    mode_i  = 1'b1;
    sel_i   = '0;
    valid_i = 4'hF;
    data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
    ready_i = 1'b1;
    @(negedge clk);
    check("rst_ready_o", 32'(ready_o), 32'h0);
    tick();
    tick();
    check("rst_valid_o", 32'(valid_o), 32'h0);
    check("rst_data_o",  32'(data_o),  32'h00);
    check("rst_ch_o",    32'(ch_o),    32'h0);

    // First round-robin grant is channel 0, then a bubble-free rotation.
    reset = 1'b0;
    @(negedge clk);
    check("rr_first_ready", 32'(ready_o), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_seq_valid", 32'(valid_o), 32'h1);
      check("rr_seq_ch",    32'(ch_o),    32'(i % 4));
      check("rr_seq_data",  32'(data_o),  32'(8'h10 + i % 4));
    end

    // Fixed grant to 3 moves the pointer; RR with 1001 then alternates 0,3,0.
    mode_i  = 1'b0;
    sel_i   = 2'd3;
    valid_i = 4'b1001;
    @(negedge clk);
    check("fix3_ready", 32'(ready_o), 32'b1000);
    tick();
    check("fix3_ch", 32'(ch_o), 32'd3);
    mode_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr1001_ready", 32'(ready_o), (i % 2 == 0) ? 32'b0001 : 32'b1000);
      tick();
      check("rr1001_ch", 32'(ch_o), (i % 2 == 0) ? 32'd0 : 32'd3);
    end

    // Fixed select of channel 2.
    mode_i  = 1'b0;
    sel_i   = 2'd2;
    valid_i = 4'b0111;
    data_i  = {8'h00, 8'hA5, 8'h22, 8'h11};
    @(negedge clk);
    check("fix2_ready", 32'(ready_o), 32'b0100);
    tick();
    check("fix2_valid", 32'(valid_o), 32'h1);
    check("fix2_data",  32'(data_o),  32'hA5);
    check("fix2_ch",    32'(ch_o),    32'd2);

    // Backpressure: hold 3C for three stalled cycles, then drain and reload.
    sel_i   = 2'd0;
    valid_i = 4'b0001;
    data_i  = {8'h00, 8'h00, 8'h00, 8'h3C};
    tick();
    check("bp_load", 32'(data_o), 32'h3C);
    ready_i = 1'b0;
    data_i  = {8'h00, 8'h00, 8'h00, 8'h77};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_o", 32'(ready_o), 32'h0);
      tick();
      check("bp_hold_data", 32'(data_o),  32'h3C);
      check("bp_hold_vld",  32'(valid_o), 32'h1);
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(ready_o), 32'b0001);
    tick();
    check("bp_reload_data", 32'(data_o),  32'h77);
    check("bp_reload_vld",  32'(valid_o), 32'h1);

    // Fixed select of a non-valid channel: no grant, register drains.
    sel_i   = 2'd3;
    valid_i = 4'b0111;
    @(negedge clk);
    check("nogrant_ready", 32'(ready_o), 32'h0);
    tick();
    check("nogrant_valid", 32'(valid_o), 32'h0);
    check("nogrant_data",  32'(data_o),  32'h77);

`ifdef RR_STREAM_MUX_CNT_EN
    // Five handshakes after reset, then saturation at the counter limit.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    mode_i  = 1'b1;
    valid_i = 4'hF;
    for (int i = 0; i < 5; i++) tick();
    valid_i = 4'h0;
    tick();
    check("cnt_five", 32'(xfer_cnt_o), 32'd5);
    valid_i = 4'hF;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    check("cnt_sat", 32'(xfer_cnt_o), 32'hFFFF);
`endif

    // Randomized traffic with occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      mode_i  = 1'($urandom);
      sel_i   = IDX_W'($urandom_range(0, NUM_CH - 1));
      valid_i = NUM_CH'($urandom);
      data_i  = (NUM_CH*WIDTH)'($urandom);
      ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
